// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: parametrised instruction memory for the pipelined MIPS core.
// Sits between the IF-stage PC and the IF/ID register. A debug-unit load engine
// streams a program into the array, after which the FSM hands control to the
// fetch path. Fetch is registered (one-cycle latency) with flush > stall > normal.
//
// Optional build macro: IMEM_READBACK_EN
//   When defined, adds a second read port (dbg_raddr / dbg_rdata) so the debug
//   unit can read back and verify a loaded program in any FSM state.
//
// Load handshake: a word is transferred on every posedge where load_valid and
// load_ready are both high. load_ready is high only in LOAD, and it is a pure
// function of state, so it never depends combinationally on load_valid. A
// load_start pulse seen in LOAD restarts the load and discards any beat offered
// in that same cycle.
module instr_mem_loadable #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 64,
  parameter int                ADDR_W   = 6,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              running,
  output logic [1:0]        state_dbg
`ifdef IMEM_READBACK_EN
  ,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] WPTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] WPTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              accept;

  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] fetch_idx;
  logic              fetch_bad;

  // Load engine: next state, write pointer and word counter.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Without a load request the preloaded image runs straight away.
        if (load_start) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
          cnt_d   = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          wptr_d = '0;
          cnt_d  = '0;
        end else if (load_valid) begin
          accept = 1'b1;
          wptr_d = wptr_q + WPTR_ONE;
          cnt_d  = cnt_q + CNT_ONE;
          // Filling the last slot ends the load even without load_last,
          // so the counter tops out at DEPTH.
          if (load_last || (wptr_q == WPTR_LAST)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Load engine state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Program array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wptr_q] <= load_data;
    end
  end

  // Fetch next-value: only RUN fetches; a restart request blanks the output.
  always_comb begin
    fetch_idx = pc[ADDR_W+1:2];
    fetch_bad = (pc[1:0] != 2'b00) || (pc[31:ADDR_W+2] != '0);
    instr_d   = instr_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    if ((state_q != ST_RUN) || load_start) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (flush) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (!stall) begin
      if (fetch_bad) begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end else begin
        instr_d = mem_q[fetch_idx];
        valid_d = 1'b1;
        fault_d = 1'b0;
      end
    end
  end

  // Fetch output registers feeding the IF/ID stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

`ifdef IMEM_READBACK_EN
  // Debug readback port, live in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_rdata <= '0;
    end else begin
      dbg_rdata <= mem_q[dbg_raddr];
    end
  end
`endif

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fetch_fault = fault_q;
  assign load_ready  = (state_q == ST_LOAD);
  assign load_done   = (state_q == ST_DONE);
  assign running     = (state_q == ST_RUN);
  assign load_count  = cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: self-checking bench for instr_mem_loadable.
// Reference model: an array image of the program memory plus the expected
// fetch outputs, derived from the fetch rules with plain arithmetic.
module tb_instr_mem_loadable;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam logic [DATA_W-1:0] NOP = '0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]       pc;
  logic              stall, flush;
  logic [DATA_W-1:0] instr;
  logic              instr_valid, fetch_fault;
  logic              load_start, load_valid, load_last;
  logic [DATA_W-1:0] load_data;
  logic              load_ready, load_done, running;
  logic [ADDR_W:0]   load_count;
  logic [1:0]        state_dbg;
`ifdef IMEM_READBACK_EN
  logic [ADDR_W-1:0] dbg_raddr;
  logic [DATA_W-1:0] dbg_rdata;
`endif

  instr_mem_loadable #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .stall(stall), .flush(flush),
    .instr(instr), .instr_valid(instr_valid), .fetch_fault(fetch_fault),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .load_count(load_count), .running(running), .state_dbg(state_dbg)
`ifdef IMEM_READBACK_EN
    , .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
`endif
  );

  // ---------------- model / scoreboard state ----------------
  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_fault;
  } vec_t;

  vec_t              vecs[12];
  logic [DATA_W-1:0] mem_m[DEPTH];
  logic [DATA_W-1:0] prog_buf[DEPTH+2];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_instr;
  logic              m_valid, m_fault;
  int                n_checks = 0;
  int                n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_valid"}, instr_valid, 1'b0);
    check({tag, "_fault"}, fetch_fault, 1'b0);
    check({tag, "_ready"}, load_ready, 1'b0);
    check({tag, "_done"}, load_done, 1'b0);
    check({tag, "_count"}, load_count, '0);
    check({tag, "_running"}, running, 1'b0);
  endtask

  // ---------------- driver tasks ----------------
  // One fetch cycle in RUN; the model applies flush > stall > normal.
  task automatic fetch(input logic [31:0] a, input logic st, input logic fl);
    int idx;
    pc = a; stall = st; flush = fl;
    if (fl) begin
      m_instr = NOP; m_valid = 1'b0; m_fault = 1'b0;
    end else if (!st) begin
      if ((a % 4) != 0 || a >= 32'(DEPTH * 4)) begin
        m_instr = NOP; m_valid = 1'b0; m_fault = 1'b1;
      end else begin
        idx = int'(a / 4);
        m_instr = mem_m[idx]; m_valid = 1'b1; m_fault = 1'b0;
      end
    end
    exp_q.push_back(m_instr);
    @(posedge clk); #1;
    check("fetch_instr", instr, exp_q.pop_front());
    check("fetch_valid", instr_valid, m_valid);
    check("fetch_fault", fetch_fault, m_fault);
    check("fetch_running", running, 1'b1);
    stall = 1'b0; flush = 1'b0;
  endtask

  // Start a load and offer n words from prog_buf back to back.
  task automatic do_load(input int n, input logic use_last);
    int   acc, done_seen, guard;
    logic fin, exp_rdy;
    acc = 0; done_seen = 0; fin = 1'b0;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    check("start_instr", instr, NOP);
    check("start_valid", instr_valid, 1'b0);
    check("start_ready", load_ready, 1'b1);
    check("start_count", load_count, '0);
    check("start_running", running, 1'b0);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = prog_buf[i];
      load_last  = use_last && (i == n - 1);
      exp_rdy    = !fin;
      check("load_ready", load_ready, exp_rdy);
      if (exp_rdy) begin
        mem_m[acc] = prog_buf[i];
        acc++;
        if (load_last || acc == DEPTH) fin = 1'b1;
      end
      @(posedge clk); #1;
      if (load_done) done_seen++;
      check("load_count", load_count, 32'(acc));
    end
    load_valid = 1'b0; load_last = 1'b0;
    guard = 0;
    while (!running && guard < 4) begin
      @(posedge clk); #1;
      if (load_done) done_seen++;
      guard++;
    end
    check("load_reaches_run", running, 1'b1);
    check("load_done_pulses", 32'(done_seen), 32'd1);
    check("load_count_held", load_count, 32'(acc));
    // Resync the fetch outputs to a known state.
    fetch(pc, 1'b0, 1'b1);
  endtask

  // ---------------- timeout guard ----------------
  initial begin
    #500000;
    $display("FAIL timeout: got running simulation expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    pc = '0; stall = 1'b0; flush = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
`ifdef IMEM_READBACK_EN
    dbg_raddr = '0;
`endif
    m_instr = NOP; m_valid = 1'b0; m_fault = 1'b0;

    // Reset, then release with no load request: RUN one cycle later.
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check("boot_running", running, 1'b1);
    check("boot_valid_first", instr_valid, 1'b0);
    pc = 32'h0;
    @(posedge clk); #1;
    check("boot_fetch_valid", instr_valid, 1'b1);
    check("boot_fetch_fault", fetch_fault, 1'b0);

    // Four-word program terminated by load_last.
    prog_buf[0] = 32'h0022_1820;
    prog_buf[1] = 32'h0022_2022;
    prog_buf[2] = 32'h0022_2824;
    prog_buf[3] = 32'h0022_3025;
    do_load(4, 1'b1);

    // Table: in-order fetch, stall hold, flush over stall, faults.
    vecs[0]  = '{32'h0000_0000, 1'b0, 1'b0, 32'h0022_1820, 1'b1, 1'b0};
    vecs[1]  = '{32'h0000_0004, 1'b0, 1'b0, 32'h0022_2022, 1'b1, 1'b0};
    vecs[2]  = '{32'h0000_0008, 1'b1, 1'b0, 32'h0022_2022, 1'b1, 1'b0};
    vecs[3]  = '{32'h0000_0008, 1'b0, 1'b0, 32'h0022_2824, 1'b1, 1'b0};
    vecs[4]  = '{32'h0000_000C, 1'b0, 1'b0, 32'h0022_3025, 1'b1, 1'b0};
    vecs[5]  = '{32'h0000_000C, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    vecs[6]  = '{32'h0000_0006, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[7]  = '{32'h0000_0100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[8]  = '{32'h0000_0104, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[9]  = '{32'h0000_0004, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    vecs[10] = '{32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[11] = '{32'h0000_0000, 1'b0, 1'b0, 32'h0022_1820, 1'b1, 1'b0};
    for (int i = 0; i < 12; i++) begin
      fetch(vecs[i].pc, vecs[i].stall, vecs[i].flush);
      check("vec_instr", instr, vecs[i].e_instr);
      check("vec_valid", instr_valid, vecs[i].e_valid);
      check("vec_fault", fetch_fault, vecs[i].e_fault);
    end

    // Overlong load without load_last: stops at DEPTH accepts.
    for (int i = 0; i < DEPTH + 2; i++) prog_buf[i] = $urandom;
    do_load(DEPTH + 2, 1'b0);
    fetch(32'h0000_00FC, 1'b0, 1'b0);
    check("last_slot_word", instr, prog_buf[DEPTH-1]);
    fetch(32'h0000_0000, 1'b0, 1'b0);
    check("first_slot_word", instr, prog_buf[0]);

    // Randomized fetch traffic with one short reload in the middle.
    for (int it = 0; it < 300; it++) begin
      if (it == 150) begin
        for (int i = 0; i < 8; i++) prog_buf[i] = $urandom;
        do_load(int'($urandom_range(1, 8)), 1'b1);
      end
      if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else a = $urandom;
      fetch(a, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    end

    // Reset during a load: two words land, the rest keep old contents.
    for (int i = 0; i < 4; i++) prog_buf[i] = $urandom;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = prog_buf[i];
      check("abort_ready", load_ready, 1'b1);
      mem_m[i] = prog_buf[i];
      @(posedge clk); #1;
    end
    check("abort_count_before", load_count, 32'd2);
    load_data = prog_buf[2];
    #2 rst = 1'b1;
    #1;
    check_reset_vals("abort");
    @(posedge clk); #1;
    check("abort_no_done", load_done, 1'b0);
    load_valid = 1'b0;
    rst = 1'b0;
    m_instr = NOP; m_valid = 1'b0; m_fault = 1'b0;
    @(posedge clk); #1;
    check("abort_running", running, 1'b1);
    check("abort_no_done_after", load_done, 1'b0);
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), 1'b0, 1'b0);
`ifdef IMEM_READBACK_EN
    dbg_raddr = 6'd1;
    @(posedge clk); #1;
    check("dbg_readback", dbg_rdata, prog_buf[1]);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Parametrised instruction memory for the pipelined MIPS core, sitting between the IF-stage PC and the IF/ID register.
- Generalises the existing fixed 32x32 memory: configurable width and depth, byte-addressed PC, fetch stall/flush, range and alignment checks.
- Adds a debug-unit load engine that streams a program in over a valid/ready handshake with an auto-incrementing write pointer, then hands control to the CPU.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 64, number of instruction words (power of two, >= 2).
- ADDR_W, 6, word-index width; must equal log2(DEPTH).
- NOP_WORD, 32'h0000_0000, value driven on flush, fault or while not running.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- pc  in  32  byte address from IF stage.
- stall  in  1  hold the current fetch output.
- flush  in  1  replace the next fetch output with NOP_WORD.
- instr  out  DATA_W  fetched instruction, registered.
- instr_valid  out  1  instr holds a real fetch.
- fetch_fault  out  1  last fetch was misaligned or out of range (registered).
- load_start  in  1  one-cycle pulse: enter LOAD, clear write pointer.
- load_valid  in  1  load_data is valid.
- load_data  in  DATA_W  instruction word to write.
- load_last  in  1  marks the final word of the program.
- load_ready  out  1  engine accepts a word this cycle.
- load_done  out  1  one-cycle pulse when LOAD completes.
- load_count  out  ADDR_W+1  number of words written in the current or last load.
- running  out  1  FSM is in RUN.

Behaviour:
- Reset (async): state=IDLE; instr=NOP_WORD; instr_valid=0; fetch_fault=0; load_ready=0; load_done=0; load_count=0; running=0. Memory array is not cleared.
- FSM states:
  - IDLE: instr=NOP_WORD, instr_valid=0, load_ready=0.
    - load_start -> LOAD.
    - Any cycle with no load_start -> RUN, so a preloaded image runs straight after reset.
  - LOAD: load_ready=1.
    - A word is written on every posedge where load_valid & load_ready: mem[wptr]<=load_data; wptr++; load_count++.
    - load_last accepted, or wptr reaching DEPTH-1 on accept -> DONE.
  - DONE: load_done=1 for exactly one cycle, load_ready=0 -> RUN.
  - RUN: running=1; fetch active.
    - load_start -> LOAD (restart); the next instr is NOP_WORD with instr_valid=0.
- load_start in LOAD: restart with wptr=0, load_count=0. A beat accepted in the same cycle is discarded.
- Fetch, RUN only, one-cycle latency:
  - Word index = pc[ADDR_W+1:2].
  - fault = (pc[1:0]!=0) | (pc[31:ADDR_W+2]!=0).
  - Priority per posedge: flush > stall > normal.
    - flush: instr=NOP_WORD, instr_valid=0, fetch_fault=0.
    - stall: all fetch outputs hold.
    - normal: fault ? (instr=NOP_WORD, instr_valid=0, fetch_fault=1) : (instr=mem[idx], instr_valid=1, fetch_fault=0).
- Outside RUN: instr=NOP_WORD, instr_valid=0, fetch_fault=0; stall and flush are ignored.
- Write and read never coincide, because load happens only in LOAD and fetch only in RUN. There is no read-during-write hazard.
- load_count saturates at DEPTH and is held after DONE until the next load_start.
- Reset mid-LOAD aborts the load: words already written remain, the rest keep their old contents, and load_done is not asserted.

Optional Feature:
- Macro IMEM_READBACK_EN.
- Defined: adds ports dbg_raddr (in, ADDR_W) and dbg_rdata (out, DATA_W).
  - dbg_rdata <= mem[dbg_raddr] on every posedge, in any state.
  - Reset value of dbg_rdata is 0.
  - Used by the debug unit to verify a loaded program.
- Undefined: the ports do not exist; no second read port is inferred.

Test Plan:
1. Reset release with no load_start -> RUN in the next cycle. pc=0 -> instr=mem[0] one posedge later; instr_valid=1.
2. Load 4 words (0x00221820, 0x00222022, 0x00222824, 0x00223025), last on word 4 -> load_done pulses once, load_count=4, running=1. pc=0,4,8,12 return those words in order with 1-cycle latency.
3. Fetch stream with stall on the 2nd fetch -> instr holds 0x00222022 for the stalled cycle. flush asserted together with stall -> next instr=0, instr_valid=0.
4. pc=0x6 -> fetch_fault=1, instr=0, instr_valid=0. pc=DEPTH*4 (0x100) -> fetch_fault=1. pc=0xFC -> valid fetch of mem[63].
5. Load DEPTH+2 words without load_last -> load_ready drops after 64 accepts, load_count=64, extra words not written, done pulse follows.
6. Assert rst after 2 of 4 words loaded -> all outputs return to reset values immediately, mem[0..1] hold the new data, mem[2..3] hold old data. With IMEM_READBACK_EN, dbg_raddr=1 -> dbg_rdata equals loaded word 2.
